// File: rtl/kernel_cache_arbiter.sv
// Round-robin arbiter sharing one Gaussian kernel generator among NUM_REQ requesters,
// with launch/wait/timeout handshake. Optional last-sigma cache: define KERNEL_CACHE_EN.
module kernel_cache_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [3*NUM_REQ-1:0] req_sigma,
    // per-requester release pulse ("release" is a reserved word)
    input  logic [NUM_REQ-1:0]   req_release,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 kernel_valid,
    output logic [31:0]          sum_out,
    output logic                 gen_start,
    output logic [2:0]           gen_sigma,
    input  logic                 gen_done,
    input  logic [31:0]          gen_sum,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_GRANT
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0] win, win_nxt, win_inc;
    logic [IDX_W-1:0] scan_idx;
    logic             scan_found;
    logic [2:0]       scan_raw, scan_sigma;
    logic [7:0]       wait_cnt, wait_cnt_nxt;
    logic [31:0]      sum_nxt;
    logic [2:0]       gen_sigma_nxt;
    logic             err_nxt;
    logic             cache_hit;

`ifdef KERNEL_CACHE_EN
    logic [2:0] cached_sigma, cached_sigma_nxt;
    logic       cache_valid, cache_valid_nxt;

    assign cache_hit = cache_valid && (scan_sigma == cached_sigma);
`else
    assign cache_hit = 1'b0;
`endif

    // First asserted request scanning upward from rr_ptr, wrapping
    always_comb begin
        int unsigned idx;
        scan_idx   = '0;
        scan_found = 1'b0;
        idx        = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!scan_found && req[idx]) begin
                scan_found = 1'b1;
                scan_idx   = IDX_W'(idx);
            end
        end
    end

    assign scan_raw   = req_sigma[3*scan_idx +: 3];
    assign scan_sigma = (scan_raw == 3'd0) ? 3'd1 : scan_raw;
    assign win_inc    = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        win_nxt       = win;
        wait_cnt_nxt  = wait_cnt;
        sum_nxt       = sum_out;
        gen_sigma_nxt = gen_sigma;
        err_nxt       = err_timeout;
`ifdef KERNEL_CACHE_EN
        cached_sigma_nxt = cached_sigma;
        cache_valid_nxt  = cache_valid;
`endif
        case (state)
            S_IDLE: begin
                if (scan_found) begin
                    win_nxt = scan_idx;
                    if (cache_hit) begin
                        state_nxt = S_GRANT;
                        err_nxt   = 1'b0;
                    end else begin
                        state_nxt     = S_LAUNCH;
                        gen_sigma_nxt = scan_sigma;
                    end
                end
            end
            S_LAUNCH: begin
                state_nxt    = S_WAIT;
                wait_cnt_nxt = '0;
            end
            S_WAIT: begin
                // done takes priority over a timeout landing on the same cycle
                if (gen_done) begin
                    sum_nxt = gen_sum;
`ifdef KERNEL_CACHE_EN
                    cached_sigma_nxt = gen_sigma;
                    cache_valid_nxt  = 1'b1;
`endif
                    if (req[win]) begin
                        state_nxt = S_GRANT;
                        err_nxt   = 1'b0;
                    end else begin
                        state_nxt  = S_IDLE;
                        rr_ptr_nxt = win_inc;
                    end
                end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                    state_nxt  = S_IDLE;
                    err_nxt    = 1'b1;
                    rr_ptr_nxt = win_inc;
`ifdef KERNEL_CACHE_EN
                    cache_valid_nxt = 1'b0;
`endif
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            S_GRANT: begin
                if (req_release[win] || !req[win]) begin
                    state_nxt  = S_IDLE;
                    rr_ptr_nxt = win_inc;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            win         <= '0;
            wait_cnt    <= '0;
            sum_out     <= '0;
            gen_sigma   <= '0;
            err_timeout <= 1'b0;
`ifdef KERNEL_CACHE_EN
            cached_sigma <= '0;
            cache_valid  <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            win         <= win_nxt;
            wait_cnt    <= wait_cnt_nxt;
            sum_out     <= sum_nxt;
            gen_sigma   <= gen_sigma_nxt;
            err_timeout <= err_nxt;
`ifdef KERNEL_CACHE_EN
            cached_sigma <= cached_sigma_nxt;
            cache_valid  <= cache_valid_nxt;
`endif
        end
    end

    // Outputs decode registered state only
    assign gnt          = (state == S_GRANT) ? (NUM_REQ'(1) << win) : '0;
    assign kernel_valid = (state == S_GRANT);
    assign gen_start    = (state == S_LAUNCH);
    assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_kernel_cache_arbiter.sv
// Self-checking bench for kernel_cache_arbiter; transaction-level model of arbitration,
// cache and timeout behaviour (cache expectations follow KERNEL_CACHE_EN).
module tb_kernel_cache_arbiter;

    localparam int N  = 2;
    localparam int TO = 64;
`ifdef KERNEL_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           n_rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [3*N-1:0] req_sigma = '0;
    logic [N-1:0]   req_release = '0;
    logic           gen_done = 1'b0;
    logic [31:0]    gen_sum = '0;
    logic [N-1:0]   gnt;
    logic           kernel_valid;
    logic [31:0]    sum_out;
    logic           gen_start;
    logic [2:0]     gen_sigma;
    logic           busy;
    logic           err_timeout;

    kernel_cache_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .n_rst(n_rst), .req(req), .req_sigma(req_sigma),
        .req_release(req_release), .gnt(gnt), .kernel_valid(kernel_valid),
        .sum_out(sum_out), .gen_start(gen_start), .gen_sigma(gen_sigma),
        .gen_done(gen_done), .gen_sum(gen_sum), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0;

    always @(negedge clk) if (gen_start === 1'b1) n_start++;

    // reference model state
    int          m_rr;
    bit          m_cv;
    logic [2:0]  m_cs;
    logic [31:0] m_sum;
    bit          m_err;

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [2:0] coerce(input logic [2:0] s);
        return (s == 3'd0) ? 3'd1 : s;
    endfunction

    function automatic int pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (r[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_cv = 0; m_cs = '0; m_sum = '0; m_err = 0;
    endtask

    task automatic do_reset();
        req = '0; req_release = '0; gen_done = 1'b0;
        n_rst = 1'b0;
        cyc();
        n_rst = 1'b1;
        model_reset();
        cyc();
    endtask

    // One full arbitration: request, optional generator run, hold, release.
    task automatic do_grant(input logic [N-1:0] mask, input logic [3*N-1:0] sig,
                            input int delay, input logic [31:0] sum,
                            input bit by_drop, input int hold, input string tag);
        int w; logic [2:0] s; bit hit; int st0; logic [N-1:0] oh; int exp_starts;
        w = pick(mask);
        s = coerce(sig[3*w +: 3]);
        hit = CACHE_EN && m_cv && (m_cs == s);
        oh = '0; oh[w] = 1'b1;
        st0 = n_start;
        exp_starts = hit ? 0 : 1;
        req = mask; req_sigma = sig;
        cyc();
        if (hit) begin
            m_err = 0;
        end else begin
            n_cmp++; if (gen_start !== 1'b1) begin n_bad++; $display("FAIL %s_start got %b want 1", tag, gen_start); end
            n_cmp++; if (gen_sigma !== s) begin n_bad++; $display("FAIL %s_sigma got %0d want %0d", tag, gen_sigma, s); end
            n_cmp++; if (err_timeout !== m_err) begin n_bad++; $display("FAIL %s_err_pre got %b want %b", tag, err_timeout, m_err); end
            cyc();
            n_cmp++; if (gen_start !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL %s_wait start=%b busy=%b want 0/1", tag, gen_start, busy); end
            repeat (delay) cyc();
            n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL %s_early_gnt got %b want 0", tag, gnt); end
            gen_done = 1'b1; gen_sum = sum;
            cyc();
            gen_done = 1'b0; gen_sum = $urandom;
            m_sum = sum; m_cv = 1; m_cs = s; m_err = 0;
        end
        n_cmp++; if (gnt !== oh) begin n_bad++; $display("FAIL %s_gnt got %b want %b", tag, gnt, oh); end
        n_cmp++; if (kernel_valid !== 1'b1) begin n_bad++; $display("FAIL %s_kv got %b want 1", tag, kernel_valid); end
        n_cmp++; if (sum_out !== m_sum) begin n_bad++; $display("FAIL %s_sum got %h want %h", tag, sum_out, m_sum); end
        n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL %s_err got %b want 0", tag, err_timeout); end
        n_cmp++; if (n_start - st0 !== exp_starts) begin n_bad++; $display("FAIL %s_nstart got %0d want %0d", tag, n_start - st0, exp_starts); end
        for (int h = 0; h < hold; h++) begin
            req_release = N'($urandom) & ~oh;
            cyc();
            req_release = '0;
            n_cmp++; if (gnt !== oh) begin n_bad++; $display("FAIL %s_hold got %b want %b", tag, gnt, oh); end
        end
        if (by_drop) req[w] = 1'b0;
        else req_release[w] = 1'b1;
        cyc();
        req_release = '0; req = '0;
        n_cmp++; if (gnt !== '0 || kernel_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL %s_rel gnt=%b kv=%b busy=%b want 0/0/0", tag, gnt, kernel_valid, busy);
        end
        m_rr = (w + 1) % N;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        #12;
        n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL rst_gnt got %b want 0", gnt); end
        n_cmp++; if (kernel_valid !== 1'b0) begin n_bad++; $display("FAIL rst_kv got %b want 0", kernel_valid); end
        n_cmp++; if (sum_out !== '0) begin n_bad++; $display("FAIL rst_sum got %h want 0", sum_out); end
        n_cmp++; if (gen_start !== 1'b0 || gen_sigma !== '0) begin n_bad++; $display("FAIL rst_gen got %b/%0d want 0/0", gen_start, gen_sigma); end
        n_cmp++; if (busy !== 1'b0 || err_timeout !== 1'b0) begin n_bad++; $display("FAIL rst_busy_err got %b/%b want 0/0", busy, err_timeout); end
        cyc();
        n_rst = 1'b1;
        model_reset();
        cyc();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_idle busy got %b want 0", busy); end
    endtask

    task automatic test_single_miss();
        do_grant(2'b01, {3'd0, 3'd2}, 12, 32'h1F4, 1'b0, 0, "miss");
        n_cmp++; if (sum_out !== 32'h1F4) begin n_bad++; $display("FAIL miss_sum_kept got %h want 1f4", sum_out); end
    endtask

    task automatic test_reset_mid_wait();
        req = 2'b01; req_sigma = {3'd0, 3'd3};
        cyc(); cyc();
        repeat (3) cyc();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmw_busy got %b want 1", busy); end
        #2 n_rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || gnt !== '0 || kernel_valid !== 1'b0) begin n_bad++; $display("FAIL rmw_state busy=%b gnt=%b kv=%b want 0", busy, gnt, kernel_valid); end
        n_cmp++; if (sum_out !== '0) begin n_bad++; $display("FAIL rmw_sum got %h want 0", sum_out); end
        n_cmp++; if (gen_start !== 1'b0 || gen_sigma !== '0 || err_timeout !== 1'b0) begin n_bad++; $display("FAIL rmw_gen got %b/%0d/%b want 0", gen_start, gen_sigma, err_timeout); end
        req = '0;
        cyc();
        n_rst = 1'b1;
        model_reset();
        cyc();
        gen_done = 1'b1; gen_sum = 32'd500;
        cyc();
        gen_done = 1'b0;
        n_cmp++; if (sum_out !== '0) begin n_bad++; $display("FAIL rmw_late_done sum got %h want 0", sum_out); end
        n_cmp++; if (gnt !== '0 || busy !== 1'b0) begin n_bad++; $display("FAIL rmw_idle gnt=%b busy=%b want 0", gnt, busy); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 3; i++)
            do_grant(2'b11, {3'd3, 3'd1}, 3 + i, 32'h100 + 32'(i), 1'b0, 1, "rr");
    endtask

    task automatic test_cache();
        do_grant(2'b01, {3'd5, 3'd2}, 4, 32'hCAFE, 1'b0, 0, "c0");
        do_grant(2'b10, {3'd2, 3'd7}, 4, 32'hBEEF, 1'b0, 0, "c1");
    endtask

    task automatic test_timeout();
        int w;
        logic [N-1:0] oh;
        w = pick(2'b01);
        req = 2'b01; req_sigma = {3'd0, 3'd5};
        cyc();
        n_cmp++; if (gen_start !== 1'b1 || gen_sigma !== 3'd5) begin n_bad++; $display("FAIL to_launch got %b/%0d want 1/5", gen_start, gen_sigma); end
        cyc();
        repeat (TO - 1) cyc();
        n_cmp++; if (busy !== 1'b1 || err_timeout !== 1'b0) begin n_bad++; $display("FAIL to_before busy=%b err=%b want 1/0", busy, err_timeout); end
        cyc();
        req = '0;
        n_cmp++; if (busy !== 1'b0 || err_timeout !== 1'b1 || gnt !== '0) begin n_bad++; $display("FAIL to_abort busy=%b err=%b gnt=%b want 0/1/0", busy, err_timeout, gnt); end
        m_err = 1; m_cv = 0; m_rr = (w + 1) % N;
        cyc();
        oh = '0;
        n_cmp++; if (err_timeout !== 1'b1 || gnt !== oh) begin n_bad++; $display("FAIL to_sticky err=%b gnt=%b want 1/0", err_timeout, gnt); end
        do_grant(2'b11, {3'd4, 3'd4}, 6, 32'h7777, 1'b0, 0, "to_retry");
    endtask

    task automatic test_sigma0_withdraw();
        do_grant(2'b01, {3'd0, 3'd0}, 2, 32'h55, 1'b1, 1, "sig0");
        req = 2'b10; req_sigma = {3'd6, 3'd0};
        cyc();
        n_cmp++; if (gen_start !== 1'b1 || gen_sigma !== 3'd6) begin n_bad++; $display("FAIL wd_launch got %b/%0d want 1/6", gen_start, gen_sigma); end
        cyc(); cyc();
        req = '0;
        cyc();
        gen_done = 1'b1; gen_sum = 32'hABCD;
        cyc();
        gen_done = 1'b0;
        m_sum = 32'hABCD; m_cv = 1; m_cs = 3'd6; m_rr = 0;
        n_cmp++; if (gnt !== '0 || busy !== 1'b0) begin n_bad++; $display("FAIL wd_nogrant gnt=%b busy=%b want 0/0", gnt, busy); end
        n_cmp++; if (sum_out !== 32'hABCD) begin n_bad++; $display("FAIL wd_sum got %h want abcd", sum_out); end
        gen_done = 1'b1; gen_sum = 32'h1234;
        cyc();
        gen_done = 1'b0;
        n_cmp++; if (sum_out !== m_sum) begin n_bad++; $display("FAIL idle_done sum got %h want %h", sum_out, m_sum); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            logic [N-1:0]   mask;
            logic [3*N-1:0] sig;
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int r = 0; r < N; r++) sig[3*r +: 3] = 3'($urandom_range(0, 3));
            do_grant(mask, sig, $urandom_range(0, 15), $urandom, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), "rnd");
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_miss();
        test_reset_mid_wait();
        test_round_robin();
        test_cache();
        test_timeout();
        test_sigma0_withdraw();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
